ibex_instr_mem_responder: RTL and testbench
===========================================

Name: ibex_instr_mem_responder

Overview:
Memory-side responder for the core's instruction fetch bus (req/gnt/rvalid, in-order, no rvalid backpressure). It accepts pipelined word fetches from the prefetcher and issues single-cycle-latency reads to a word-addressed SRAM/ROM macro. Responses are returned in order with a configurable minimum latency and a bounded number of outstanding requests. Addresses outside the mapped window return an error response. It is used in the boot-ROM/instruction-RAM subsystem and as a synthesizable bench responder.

Parameters:
Depth, 2, maximum granted-but-unanswered requests (>=1); entry pointers wrap at Depth-1 to 0, so Depth need not be a power of two
MemAddrWidth, 12, word-address width of the backing memory (window = 4*2^MemAddrWidth bytes)
BaseAddr, 32'h0000_0000, byte base of the window, aligned to the window size
RespLatency, 1, minimum cycles from grant to rvalid (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  request accepted this cycle
instr_addr_i  in  32  byte address; bits [1:0] ignored
instr_rvalid_o  out  1  response valid, one cycle per granted request
instr_rdata_o  out  32  response data
instr_err_o  out  1  response error (address out of window)
mem_req_o  out  1  memory read strobe
mem_addr_o  out  MemAddrWidth  word address, (instr_addr_i - BaseAddr) >> 2
mem_rdata_i  in  32  read data, valid the cycle after mem_req_o
stall_i  in  1  force instr_gnt_o low (wait-state injection)
outstanding_o  out  $clog2(Depth+1)  granted-not-yet-responded count
busy_o  out  1  outstanding_o != 0

Behaviour:
- Reset is asynchronous, active-low, on rst_ni with clock clk_i. During/after reset: all entries invalid; instr_gnt_o, instr_rvalid_o, instr_err_o, mem_req_o, busy_o = 0; instr_rdata_o = 0; outstanding_o = 0; mem_addr_o = 0.
- Grant (combinational): instr_gnt_o = instr_req_i & ~stall_i & (outstanding_o < Depth). A same-cycle rvalid pop does NOT free a slot for a same-cycle grant.
- in_range = instr_addr_i within [BaseAddr, BaseAddr + 4*2^MemAddrWidth). mem_req_o = instr_gnt_o & in_range. mem_addr_o is driven from instr_addr_i whenever mem_req_o=1, else 0.
- On grant in cycle T: write an entry at wr_ptr with err=~in_range, data_valid=in_range?0:1, data=0, countdown=RespLatency-1. Advance wr_ptr.
- In cycle T+1: if that request was in range, capture mem_rdata_i into the entry and set data_valid. A one-deep register remembers the pending capture entry index.
- Countdown: every valid entry with countdown>0 decrements by 1 per cycle.
- Response: the head entry (rd_ptr) is ready when countdown==0 and (data_valid or its capture is this cycle). If ready: instr_rvalid_o=1, instr_err_o=entry err, instr_rdata_o = bypass mem_rdata_i if capture this cycle, else stored data (0 for err). Invalidate the entry and advance rd_ptr.
- Bypass is mandatory: with RespLatency=1 an in-range grant at T gives rvalid at T+1 carrying mem_rdata_i.
- When instr_rvalid_o=0, instr_rdata_o=0 and instr_err_o=0.
- Ordering: responses are strictly in grant order. At most one grant and one response per cycle, so the entry store cannot overflow.
- outstanding_o: +1 on grant, -1 on rvalid; both in the same cycle leaves it unchanged. It never exceeds Depth and never underflows.
- Requestor contract (not checked): addr is held stable while req=1 and gnt=0.
- Out-of-window requests still occupy a slot and obey RespLatency. They never assert mem_req_o.
- Reset mid-operation discards all outstanding requests; no rvalid is produced for them.
- Throughput: 1 response/cycle when Depth >= RespLatency+1; otherwise Depth grants per RespLatency+1 cycles.

Test Plan:
- Reset: hold rst_ni=0 with instr_req_i=1 -> gnt, rvalid, mem_req_o, outstanding_o all 0. Release -> gnt=1 in the first cycle.
- Back-to-back (Depth=2, RespLatency=1): req held, addrs 0x0/0x4/0x8/0xC, memory returns 0xA0+word -> gnt on 4 consecutive cycles. rvalid on the next 4 cycles with rdata 0xA0, 0xA1, 0xA2, 0xA3. outstanding_o <= 1.
- Out-of-window (BaseAddr=0, MemAddrWidth=12): addr 0x4000 -> gnt=1, mem_req_o=0. The next cycle gives rvalid=1, err=1, rdata=0. The following in-range fetch at 0x3FFC gives mem_addr_o=0xFFF and err=0.
- Full (Depth=2, RespLatency=3): req held high -> gnt pattern 1,1,0,0,1,1,0,0. outstanding_o reaches 2. Each rvalid comes exactly 3 cycles after its grant, in order.
- Stall: stall_i=1 for 3 cycles with req=1, addr=0x10 -> gnt=0, mem_req_o=0. On the stall_i=0 cycle, gnt=1 and mem_addr_o=0x4.
- Reset mid-operation (RespLatency=3): two grants, then rst_ni=0 for 1 cycle -> no rvalid for either. outstanding_o=0, and the next grant responds normally.

Source files
------------

// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch bus responder: grants pipelined word fetches into a single-cycle SRAM/ROM
// and returns in-order responses no sooner than RespLatency cycles after grant, Depth deep.
module ibex_instr_mem_responder #(
  parameter int unsigned Depth        = 2,
  parameter int unsigned MemAddrWidth = 12,
  parameter logic [31:0] BaseAddr     = 32'h0000_0000,
  parameter int unsigned RespLatency  = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        instr_req_i,
  output logic                        instr_gnt_o,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  output logic                        mem_req_o,
  output logic [MemAddrWidth-1:0]     mem_addr_o,
  input  logic [31:0]                 mem_rdata_i,
  input  logic                        stall_i,
  output logic [$clog2(Depth+1)-1:0]  outstanding_o,
  output logic                        busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned LatW = (RespLatency > 1) ? $clog2(RespLatency) : 1;

  logic [Depth-1:0]  r_vld;
  logic [Depth-1:0]  r_err;
  logic [Depth-1:0]  r_dvld;
  logic [31:0]       r_data [Depth];
  logic [LatW-1:0]   r_cnt  [Depth];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW-1:0]   r_cap_idx;
  logic              r_cap_pend;
  logic [CntW-1:0]   r_outstanding;

  logic [31:0]       w_offset;
  logic              w_in_range;
  logic              w_gnt;
  logic              w_head_cap;
  logic              w_pop;

  function automatic logic [PtrW-1:0] f_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // BaseAddr is window-aligned, so any bit set above the window means out of range
  assign w_offset   = instr_addr_i - BaseAddr;
  assign w_in_range = (w_offset >> (MemAddrWidth + 2)) == 32'd0;

  // A same-cycle pop deliberately does not free a slot for this grant
  assign w_gnt = rst_ni & instr_req_i & ~stall_i & (r_outstanding < CntW'(Depth));

  assign instr_gnt_o = w_gnt;
  assign mem_req_o   = w_gnt & w_in_range;
  assign mem_addr_o  = mem_req_o ? w_offset[MemAddrWidth+1:2] : '0;

  assign w_head_cap = r_cap_pend & (r_cap_idx == r_rd_ptr);
  assign w_pop      = r_vld[r_rd_ptr] & (r_cnt[r_rd_ptr] == '0)
                    & (r_dvld[r_rd_ptr] | w_head_cap);

  assign instr_rvalid_o = w_pop;
  assign instr_err_o    = w_pop & r_err[r_rd_ptr];
  assign instr_rdata_o  = !w_pop    ? 32'd0 :
                          w_head_cap ? mem_rdata_i : r_data[r_rd_ptr];

  assign outstanding_o = r_outstanding;
  assign busy_o        = (r_outstanding != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld         <= '0;
      r_err         <= '0;
      r_dvld        <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_cap_idx     <= '0;
      r_cap_pend    <= 1'b0;
      r_outstanding <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_data[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (r_vld[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - LatW'(1);
        end
        if (r_cap_pend && (r_cap_idx == PtrW'(i))) begin
          r_data[i] <= mem_rdata_i;
          r_dvld[i] <= 1'b1;
        end
      end

      if (w_pop) begin
        r_vld[r_rd_ptr]  <= 1'b0;
        r_dvld[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= f_next(r_rd_ptr);
      end

      // The write slot is never valid, so it cannot collide with the pop or capture slot
      if (w_gnt) begin
        r_vld[r_wr_ptr]  <= 1'b1;
        r_err[r_wr_ptr]  <= ~w_in_range;
        r_dvld[r_wr_ptr] <= ~w_in_range;
        r_data[r_wr_ptr] <= '0;
        r_cnt[r_wr_ptr]  <= LatW'(RespLatency - 1);
        r_wr_ptr         <= f_next(r_wr_ptr);
      end

      r_cap_pend    <= mem_req_o;
      r_cap_idx     <= r_wr_ptr;
      r_outstanding <= r_outstanding + CntW'(w_gnt) - CntW'(w_pop);
    end
  end

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Directed bench: instance A (Depth=2, RespLatency=1) and instance B (Depth=2, RespLatency=3),
// each with a memory model returning 0xA0 + word address one cycle after mem_req_o.
module tb_ibex_instr_mem_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req, a_gnt, a_rvalid, a_err, a_mem_req, a_stall, a_busy;
  logic [31:0] a_addr, a_rdata, a_mem_rdata;
  logic [11:0] a_mem_addr;
  logic [1:0]  a_out;

  logic        b_req, b_gnt, b_rvalid, b_err, b_mem_req, b_stall, b_busy;
  logic [31:0] b_addr, b_rdata, b_mem_rdata;
  logic [11:0] b_mem_addr;
  logic [1:0]  b_out;

  int n_tests = 0;
  int n_fail  = 0;

  ibex_instr_mem_responder #(
    .Depth(2), .MemAddrWidth(12), .BaseAddr(32'h0), .RespLatency(1)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(a_req), .instr_gnt_o(a_gnt), .instr_addr_i(a_addr),
    .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata), .instr_err_o(a_err),
    .mem_req_o(a_mem_req), .mem_addr_o(a_mem_addr), .mem_rdata_i(a_mem_rdata),
    .stall_i(a_stall), .outstanding_o(a_out), .busy_o(a_busy)
  );

  ibex_instr_mem_responder #(
    .Depth(2), .MemAddrWidth(12), .BaseAddr(32'h0), .RespLatency(3)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(b_req), .instr_gnt_o(b_gnt), .instr_addr_i(b_addr),
    .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata), .instr_err_o(b_err),
    .mem_req_o(b_mem_req), .mem_addr_o(b_mem_addr), .mem_rdata_i(b_mem_rdata),
    .stall_i(b_stall), .outstanding_o(b_out), .busy_o(b_busy)
  );

  // Read data is only meaningful the cycle after a strobe; otherwise show garbage
  always @(posedge clk) begin
    a_mem_rdata <= a_mem_req ? (32'hA0 + {20'd0, a_mem_addr}) : 32'hDEAD_BEEF;
    b_mem_rdata <= b_mem_req ? (32'hA0 + {20'd0, b_mem_addr}) : 32'hDEAD_BEEF;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_req = 1'b1; a_addr = 32'h40; a_stall = 1'b0;
    b_req = 1'b0; b_addr = 32'h0; b_stall = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (a_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", a_gnt); end
    n_tests++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", a_rvalid); end
    n_tests++; if (a_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", a_mem_req); end
    n_tests++; if (a_mem_addr !== 12'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", a_mem_addr); end
    n_tests++; if (a_out !== 2'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", a_out); end
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    n_tests++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", a_rdata); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL reset_release_gnt: got %b expected 1", a_gnt); end
    n_tests++; if (a_mem_addr !== 12'h010) begin n_fail++; $display("FAIL reset_release_mem_addr: got %h expected 010", a_mem_addr); end
    next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    n_tests++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hB0) begin
      n_fail++; $display("FAIL reset_first_resp: got rvalid=%b rdata=%h expected 1/000000b0", a_rvalid, a_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_tests++; if (a_out !== 2'd0) begin n_fail++; $display("FAIL reset_drain_outstanding: got %0d expected 0", a_out); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      a_req  = (c < 4);
      a_addr = 32'(c * 4);
      @(negedge clk);
      if (c < 4) begin
        n_tests++; if (a_gnt !== 1'b1 || a_mem_addr !== 12'(c)) begin
          n_fail++; $display("FAIL b2b_gnt c%0d: got gnt=%b mem_addr=%h expected 1/%h", c, a_gnt, a_mem_addr, 12'(c));
        end
      end
      n_tests++; if (a_out !== ((c == 0 || c == 5) ? 2'd0 : 2'd1)) begin
        n_fail++; $display("FAIL b2b_outstanding c%0d: got %0d", c, a_out);
      end
      if (c >= 1 && c <= 4) begin
        n_tests++; if (a_rvalid !== 1'b1 || a_err !== 1'b0 || a_rdata !== 32'(32'hA0 + c - 1)) begin
          n_fail++; $display("FAIL b2b_resp c%0d: got rvalid=%b err=%b rdata=%h expected 1/0/%h",
                             c, a_rvalid, a_err, a_rdata, 32'(32'hA0 + c - 1));
        end
      end else begin
        n_tests++; if (a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin
          n_fail++; $display("FAIL b2b_idle c%0d: got rvalid=%b rdata=%h expected 0/0", c, a_rvalid, a_rdata);
        end
      end
    end
  endtask

  task automatic test_out_of_window();
    next_cycle();
    a_req = 1'b1; a_addr = 32'h4000;
    @(negedge clk);
    n_tests++; if (a_gnt !== 1'b1 || a_mem_req !== 1'b0 || a_mem_addr !== 12'h0) begin
      n_fail++; $display("FAIL oow_grant: got gnt=%b mem_req=%b mem_addr=%h expected 1/0/000", a_gnt, a_mem_req, a_mem_addr);
    end
    next_cycle();
    a_addr = 32'h3FFC;
    @(negedge clk);
    n_tests++; if (a_rvalid !== 1'b1 || a_err !== 1'b1 || a_rdata !== 32'h0) begin
      n_fail++; $display("FAIL oow_resp: got rvalid=%b err=%b rdata=%h expected 1/1/0", a_rvalid, a_err, a_rdata);
    end
    n_tests++; if (a_gnt !== 1'b1 || a_mem_req !== 1'b1 || a_mem_addr !== 12'hFFF) begin
      n_fail++; $display("FAIL oow_edge_grant: got gnt=%b mem_req=%b mem_addr=%h expected 1/1/fff", a_gnt, a_mem_req, a_mem_addr);
    end
    next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    n_tests++; if (a_rvalid !== 1'b1 || a_err !== 1'b0 || a_rdata !== 32'h109F) begin
      n_fail++; $display("FAIL oow_edge_resp: got rvalid=%b err=%b rdata=%h expected 1/0/0000109f", a_rvalid, a_err, a_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_tests++; if (a_rvalid !== 1'b0 || a_err !== 1'b0) begin
      n_fail++; $display("FAIL oow_idle: got rvalid=%b err=%b expected 0/0", a_rvalid, a_err);
    end
  endtask

  task automatic test_full();
    bit exp_gnt [12];
    bit exp_rv  [12];
    int ng = 0;
    int nr = 0;
    exp_gnt = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_rv  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      b_req  = (c < 8);
      b_addr = 32'(ng * 4);
      @(negedge clk);
      n_tests++; if (b_gnt !== exp_gnt[c]) begin
        n_fail++; $display("FAIL full_gnt c%0d: got %b expected %b", c, b_gnt, exp_gnt[c]);
      end
      n_tests++; if (b_rvalid !== exp_rv[c]) begin
        n_fail++; $display("FAIL full_rvalid c%0d: got %b expected %b", c, b_rvalid, exp_rv[c]);
      end
      if (b_rvalid === 1'b1) begin
        n_tests++; if (b_rdata !== 32'(32'hA0 + nr) || b_err !== 1'b0) begin
          n_fail++; $display("FAIL full_rdata c%0d: got %h err=%b expected %h err=0", c, b_rdata, b_err, 32'(32'hA0 + nr));
        end
        nr++;
      end
      if (c == 2 || c == 3) begin
        n_tests++; if (b_out !== 2'd2) begin n_fail++; $display("FAIL full_outstanding c%0d: got %0d expected 2", c, b_out); end
      end
      if (b_gnt === 1'b1) ng++;
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      a_req   = (c < 4);
      a_addr  = 32'h10;
      a_stall = (c < 3);
      @(negedge clk);
      if (c < 3) begin
        n_tests++; if (a_gnt !== 1'b0 || a_mem_req !== 1'b0) begin
          n_fail++; $display("FAIL stall_hold c%0d: got gnt=%b mem_req=%b expected 0/0", c, a_gnt, a_mem_req);
        end
      end else if (c == 3) begin
        n_tests++; if (a_gnt !== 1'b1 || a_mem_addr !== 12'h004) begin
          n_fail++; $display("FAIL stall_release: got gnt=%b mem_addr=%h expected 1/004", a_gnt, a_mem_addr);
        end
      end else if (c == 4) begin
        n_tests++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hA4) begin
          n_fail++; $display("FAIL stall_resp: got rvalid=%b rdata=%h expected 1/000000a4", a_rvalid, a_rdata);
        end
      end else begin
        n_tests++; if (a_rvalid !== 1'b0 || a_out !== 2'd0) begin
          n_fail++; $display("FAIL stall_idle: got rvalid=%b outstanding=%0d expected 0/0", a_rvalid, a_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    b_req = 1'b1; b_addr = 32'h20;
    @(negedge clk);
    n_tests++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt0: got %b expected 1", b_gnt); end
    next_cycle();
    b_addr = 32'h24;
    @(negedge clk);
    n_tests++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt1: got %b expected 1", b_gnt); end
    next_cycle();
    b_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (b_out !== 2'd0 || b_rvalid !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_in_reset: got outstanding=%0d rvalid=%b busy=%b expected 0/0/0", b_out, b_rvalid, b_busy);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_resp c%0d: got rvalid=%b expected 0", c, b_rvalid); end
      next_cycle();
    end
    for (int c = 0; c < 5; c++) begin
      b_req  = (c == 0);
      b_addr = 32'h28;
      @(negedge clk);
      if (c == 0) begin
        n_tests++; if (b_gnt !== 1'b1 || b_mem_addr !== 12'h00A) begin
          n_fail++; $display("FAIL rstmid_regrant: got gnt=%b mem_addr=%h expected 1/00a", b_gnt, b_mem_addr);
        end
      end
      if (c == 1) begin
        n_tests++; if (b_out !== 2'd1) begin n_fail++; $display("FAIL rstmid_outstanding: got %0d expected 1", b_out); end
      end
      n_tests++; if (b_rvalid !== (c == 3)) begin
        n_fail++; $display("FAIL rstmid_resp_timing c%0d: got rvalid=%b expected %b", c, b_rvalid, (c == 3));
      end
      if (c == 3) begin
        n_tests++; if (b_rdata !== 32'hAA || b_err !== 1'b0) begin
          n_fail++; $display("FAIL rstmid_resp_data: got %h err=%b expected 000000aa err=0", b_rdata, b_err);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_out_of_window();
    test_full();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
